// File: rtl/riscv_pkg.sv
// Shared encodings for the control sequencer: opcode/funct fields, ALU control and sequencer states.
package riscv_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        TRAP  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational decode of one instruction word into datapath controls.
module instr_decoder
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] ir,
    output logic [4:0]      ad1,
    output logic [4:0]      ad2,
    output logic [4:0]      ad3,
    output logic            wen,
    output logic            aluSrc,
    output alu_ctrl_e       aluCTR,
    output logic [XLEN-1:0] immOp,
    output logic            isBranch,
    output logic            brNe,
    output logic            legal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            rdNonZero;
    logic [XLEN-1:0] immI;
    logic [XLEN-1:0] immB;

    assign opcode    = ir[6:0];
    assign funct3    = ir[14:12];
    assign funct7    = ir[31:25];
    assign ad1       = ir[19:15];
    assign ad2       = ir[24:20];
    assign ad3       = ir[11:7];
    assign rdNonZero = |ir[11:7];

    assign immI = {{(XLEN-12){ir[31]}}, ir[31:20]};
    assign immB = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

    always_comb begin
        wen      = 1'b0;
        aluSrc   = 1'b0;
        aluCTR   = ALU_ADD;
        immOp    = '0;
        isBranch = 1'b0;
        brNe     = 1'b0;
        legal    = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                if (funct3 == F3_ADD) begin
                    legal  = 1'b1;
                    wen    = rdNonZero;
                    aluSrc = 1'b1;
                    immOp  = immI;
                end
            end
            OPC_OP: begin
                if (funct3 == F3_ADD && (funct7 == F7_ADD || funct7 == F7_SUB)) begin
                    legal  = 1'b1;
                    wen    = rdNonZero;
                    aluCTR = (funct7 == F7_SUB) ? ALU_SUB : ALU_ADD;
                end
            end
            OPC_BRANCH: begin
                // Branch compare is done by the ALU as rs1-rs2; the datapath reports eq.
                if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
                    legal    = 1'b1;
                    isBranch = 1'b1;
                    brNe     = (funct3 == F3_BNE);
                    aluCTR   = ALU_SUB;
                    immOp    = immB;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns pc and IR, drives the register-file/ALU datapath controls.
module control_sequencer
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic            imemAck,
    input  logic [XLEN-1:0] imemData,
    output logic [4:0]      ad1,
    output logic [4:0]      ad2,
    output logic [4:0]      ad3,
    output logic            we3,
    output logic            aluSrc,
    output logic [2:0]      aluCTR,
    output logic [XLEN-1:0] immOp,
    input  logic            eq,
    output logic [XLEN-1:0] pc,
    output logic            illegal
);

    seq_state_e      stateReg, stateNext;
    logic [XLEN-1:0] pcReg, pcNext;
    logic [XLEN-1:0] irReg, irNext;
    logic            illegalReg, illegalNext;
    logic            reqEnReg;

    logic            decWen;
    logic            decAluSrc;
    alu_ctrl_e       decAluCtr;
    logic [XLEN-1:0] decImm;
    logic            decIsBranch;
    logic            decBrNe;
    logic            decLegal;

    logic            inExec;
    logic            brTaken;
    logic [XLEN-1:0] brTarget;
    logic [XLEN-1:0] seqPc;

    instr_decoder #(
        .XLEN(XLEN)
    ) u_decoder (
        .ir      (irReg),
        .ad1     (ad1),
        .ad2     (ad2),
        .ad3     (ad3),
        .wen     (decWen),
        .aluSrc  (decAluSrc),
        .aluCTR  (decAluCtr),
        .immOp   (decImm),
        .isBranch(decIsBranch),
        .brNe    (decBrNe),
        .legal   (decLegal)
    );

    assign brTaken  = decIsBranch & (decBrNe ? ~eq : eq);
    assign brTarget = pcReg + decImm;
    assign seqPc    = pcReg + XLEN'(4);

    // reqEnReg keeps imemReq low for the first cycle after reset so an
    // abandoned fetch's late ack cannot be mistaken for a new one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stateReg   <= FETCH;
            pcReg      <= RESET_PC;
            irReg      <= XLEN'(NOP_INSN);
            illegalReg <= 1'b0;
            reqEnReg   <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            pcReg      <= pcNext;
            irReg      <= irNext;
            illegalReg <= illegalNext;
            reqEnReg   <= 1'b1;
        end
    end

    always_comb begin
        stateNext   = stateReg;
        pcNext      = pcReg;
        irNext      = irReg;
        illegalNext = illegalReg;
        imemReq     = 1'b0;
        we3         = 1'b0;
        case (stateReg)
            FETCH: begin
                imemReq = reqEnReg;
                if (reqEnReg && imemAck) begin
                    irNext    = imemData;
                    stateNext = EXEC;
                end
            end
            EXEC: begin
                if (!decLegal || (brTaken && brTarget[1:0] != 2'b00)) begin
                    illegalNext = 1'b1;
                    stateNext   = TRAP;
                end else begin
                    we3       = decWen;
                    pcNext    = brTaken ? brTarget : seqPc;
                    stateNext = FETCH;
                end
            end
            TRAP:    ;
            default: stateNext = TRAP;
        endcase
    end

    assign inExec   = (stateReg == EXEC);
    assign aluSrc   = inExec & decAluSrc;
    assign aluCTR   = inExec ? decAluCtr : ALU_ADD;
    assign immOp    = inExec ? decImm : '0;
    assign imemAddr = pcReg;
    assign pc       = pcReg;
    assign illegal  = illegalReg;

endmodule
